// File: rtl/opc5_arb_pkg.sv
// ----------------------------------------------------------------------------
// opc5_arb_pkg
// Shared types and constants for the OPC5 two-master memory arbiter.
//   - arb_state_e  : arbiter FSM states (IDLE, ACCESS, DONE)
//   - M_CPU/M_AUX  : master index encodings used for grants
//   - ARB_AW/ARB_DW: default address/data widths
//   - cnt_width()  : wait-counter width for a given wait-state count
// ----------------------------------------------------------------------------
package opc5_arb_pkg;

    localparam int unsigned ARB_AW = 16;
    localparam int unsigned ARB_DW = 16;

    // Master indices; also the encoding of the grant/last_grant bits.
    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    // Counter must hold WAIT_STATES; keep at least one bit for WAIT_STATES = 0.
    function automatic int unsigned cnt_width(input int unsigned ws);
        return (ws == 0) ? 1 : $clog2(ws + 1);
    endfunction

endpackage

// File: rtl/opc5_arb_pick.sv
// ----------------------------------------------------------------------------
// opc5_arb_pick
// Winner selection for the two-master arbiter. Holds the last_grant register
// and combinationally picks a winner from the two request lines.
//
// Build option:
//   OPC_ARB_FIXED_PRIORITY_EN defined   -> master 0 always wins contention,
//                                          last_grant is not kept.
//   OPC_ARB_FIXED_PRIORITY_EN undefined -> round robin on last_grant.
//
// Ports:
//   clk, reset_b    : clock, synchronous active-low reset
//   req_i[1:0]      : request lines, bit 0 = CPU, bit 1 = AUX
//   done_i          : strobe, high while the arbiter is in DONE
//   done_idx_i      : master that completed (recorded as last_grant)
//   win_idx_o_c     : selected master (combinational)
//   win_vld_o_c     : at least one request present (combinational)
// ----------------------------------------------------------------------------
module opc5_arb_pick
    import opc5_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_b,
    input  logic [1:0] req_i,
    input  logic       done_i,
    input  logic       done_idx_i,
    output logic       win_idx_o_c,
    output logic       win_vld_o_c
);

`ifdef OPC_ARB_FIXED_PRIORITY_EN

    // No history needed: CPU wins every tie.
    logic unused_done;
    assign unused_done = &{1'b0, clk, reset_b, done_i, done_idx_i};

    always_comb begin
        win_vld_o_c = |req_i;
        win_idx_o_c = M_CPU;
        if (req_i[1] && !req_i[0]) begin
            win_idx_o_c = M_AUX;
        end
    end

`else

    logic last_grant_q;
    logic last_grant_d;

    // Reset to AUX so the CPU wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            last_grant_q <= M_AUX;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (done_i) begin
            last_grant_d = done_idx_i;
        end
    end

    // Single requester always wins; on a tie the master not granted last wins.
    always_comb begin
        win_vld_o_c = |req_i;
        win_idx_o_c = M_CPU;
        unique case (req_i)
            2'b10:   win_idx_o_c = M_AUX;
            2'b11:   win_idx_o_c = ~last_grant_q;
            default: win_idx_o_c = M_CPU;
        endcase
    end

`endif

endmodule

// File: rtl/opc5_mem_arbiter.sv
// ----------------------------------------------------------------------------
// opc5_mem_arbiter
// Shares one synchronous 64K x 16 memory port between the OPC5 CPU (master 0)
// and an auxiliary requester (master 1, e.g. DMA/loader). Each access runs
// IDLE -> ACCESS (WAIT_STATES + 1 cycles) -> DONE (ack pulse), giving one
// access per WAIT_STATES + 3 cycles. All outputs are registered.
//
// Build option:
//   OPC_ARB_FIXED_PRIORITY_EN : fixed CPU priority instead of round robin
//                               (selected inside opc5_arb_pick).
//
// Parameters:
//   AW          : address width
//   DW          : data width
//   WAIT_STATES : extra cycles the memory port is held per access (0..15)
//
// Ports:
//   clk, reset_b                         : clock, synchronous active-low reset
//   m0_req/m0_rnw/m0_addr/m0_wdata       : CPU request (held until ack)
//   m0_ack/m0_rdata                      : CPU completion pulse, read data
//   m1_req/m1_rnw/m1_addr/m1_wdata       : AUX request (held until ack)
//   m1_ack/m1_rdata                      : AUX completion pulse, read data
//   mem_ceb/mem_rnw/mem_addr/mem_wdata   : memory port (ceb active low)
//   mem_rdata                            : memory read data, valid the cycle
//                                          after the address is presented
// ----------------------------------------------------------------------------
module opc5_mem_arbiter
    import opc5_arb_pkg::*;
#(
    parameter int unsigned AW          = ARB_AW,
    parameter int unsigned DW          = ARB_DW,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          reset_b,

    input  logic          m0_req,
    input  logic          m0_rnw,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_rnw,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_ceb,
    output logic          mem_rnw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = cnt_width(WAIT_STATES);

    arb_state_e    state_q,     state_d;
    logic [CW-1:0] wait_cnt_q,  wait_cnt_d;
    logic          win_q,       win_d;
    logic          mem_ceb_q,   mem_ceb_d;
    logic          mem_rnw_q,   mem_rnw_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          m0_ack_q,    m0_ack_d;
    logic          m1_ack_q,    m1_ack_d;
    logic [DW-1:0] m0_rdata_q,  m0_rdata_d;
    logic [DW-1:0] m1_rdata_q,  m1_rdata_d;

    logic          pick_idx_c;
    logic          pick_vld_c;
    logic          done_c;

    assign done_c = (state_q == DONE);

    // Winner selection and last_grant history.
    opc5_arb_pick u_pick (
        .clk         (clk),
        .reset_b     (reset_b),
        .req_i       ({m1_req, m0_req}),
        .done_i      (done_c),
        .done_idx_i  (win_q),
        .win_idx_o_c (pick_idx_c),
        .win_vld_o_c (pick_vld_c)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            win_q       <= M_CPU;
            mem_ceb_q   <= 1'b1;
            mem_rnw_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            win_q       <= win_d;
            mem_ceb_q   <= mem_ceb_d;
            mem_rnw_q   <= mem_rnw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        win_d       = win_q;
        mem_ceb_d   = mem_ceb_q;
        mem_rnw_d   = mem_rnw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        m0_ack_d    = m0_ack_q;
        m1_ack_d    = m1_ack_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;

        unique case (state_q)
            IDLE: begin
                // Latch the winner's transaction onto the memory port.
                if (pick_vld_c) begin
                    win_d      = pick_idx_c;
                    mem_ceb_d  = 1'b0;
                    wait_cnt_d = CW'(WAIT_STATES);
                    state_d    = ACCESS;
                    if (pick_idx_c == M_AUX) begin
                        mem_rnw_d   = m1_rnw;
                        mem_addr_d  = m1_addr;
                        mem_wdata_d = m1_wdata;
                    end else begin
                        mem_rnw_d   = m0_rnw;
                        mem_addr_d  = m0_addr;
                        mem_wdata_d = m0_wdata;
                    end
                end
            end

            ACCESS: begin
                // Memory port held stable until the wait count runs out.
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - CW'(1);
                end else begin
                    mem_ceb_d = 1'b1;
                    mem_rnw_d = 1'b1;
                    state_d   = DONE;
                    if (win_q == M_AUX) begin
                        m1_ack_d = 1'b1;
                        if (mem_rnw_q) begin
                            m1_rdata_d = mem_rdata;
                        end
                    end else begin
                        m0_ack_d = 1'b1;
                        if (mem_rnw_q) begin
                            m0_rdata_d = mem_rdata;
                        end
                    end
                end
            end

            DONE: begin
                // Ack was high for this single cycle; last_grant updates in the picker.
                m0_ack_d = 1'b0;
                m1_ack_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign mem_ceb   = mem_ceb_q;
    assign mem_rnw   = mem_rnw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_opc5_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_opc5_mem_arbiter
// Three arbiter instances (WAIT_STATES = 0, 2, 3) share one clock, each with
// its own memory model. Stimulus pushes expected acks and expected port levels
// (keyed by cycle number) into queues; a negedge monitor pops and compares.
// ----------------------------------------------------------------------------
module tb_opc5_mem_arbiter;

    localparam int NI = 3;

    function automatic int unsigned ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    typedef enum int {L_CEB, L_RNW, L_ADDR, L_WDATA, L_RD0, L_RD1} lk_e;

    typedef struct {
        int          inst;
        int          m;
        int          cyc;
        bit          chk;
        logic [15:0] rd;
        logic [63:0] tag;
    } ack_t;

    typedef struct {
        int          inst;
        lk_e         k;
        int          cyc;
        logic [15:0] v;
        logic [63:0] tag;
    } lvl_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    bit          done = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        reset_b   [NI];
    logic        req0      [NI];
    logic        rnw0      [NI];
    logic [15:0] addr0     [NI];
    logic [15:0] wdata0    [NI];
    logic        req1      [NI];
    logic        rnw1      [NI];
    logic [15:0] addr1     [NI];
    logic [15:0] wdata1    [NI];
    logic        ack0      [NI];
    logic        ack1      [NI];
    logic [15:0] rdata0    [NI];
    logic [15:0] rdata1    [NI];
    logic        mem_ceb   [NI];
    logic        mem_rnw   [NI];
    logic [15:0] mem_addr  [NI];
    logic [15:0] mem_wdata [NI];
    logic [15:0] mem_rdata [NI];

    logic [15:0] mem [NI][65536];
    bit          loaded = 1'b0;

    ack_t aq[$];
    lvl_t lq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        opc5_mem_arbiter #(
            .AW          (16),
            .DW          (16),
            .WAIT_STATES (ws_of(g))
        ) u_dut (
            .clk       (clk),
            .reset_b   (reset_b[g]),
            .m0_req    (req0[g]),
            .m0_rnw    (rnw0[g]),
            .m0_addr   (addr0[g]),
            .m0_wdata  (wdata0[g]),
            .m0_ack    (ack0[g]),
            .m0_rdata  (rdata0[g]),
            .m1_req    (req1[g]),
            .m1_rnw    (rnw1[g]),
            .m1_addr   (addr1[g]),
            .m1_wdata  (wdata1[g]),
            .m1_ack    (ack1[g]),
            .m1_rdata  (rdata1[g]),
            .mem_ceb   (mem_ceb[g]),
            .mem_rnw   (mem_rnw[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );

        // Read data follows the registered address within the access cycle.
        assign mem_rdata[g] = mem[g][mem_addr[g]];
    end

    // Memory model: preload, then commit writes on every enabled write edge.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < NI; i++) begin
                mem[i][16'h0100] <= 16'hBEEF;
                mem[i][16'h0200] <= 16'h1111;
                mem[i][16'h0300] <= 16'h2222;
                mem[i][16'hFFFF] <= 16'h0000;
            end
            loaded <= 1'b1;
        end
        for (int i = 0; i < NI; i++) begin
            if (!mem_ceb[i] && !mem_rnw[i]) begin
                mem[i][mem_addr[i]] <= mem_wdata[i];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void exp_ack(input int inst, input int m, input int c,
                                    input bit chk, input logic [15:0] rd,
                                    input logic [63:0] tag);
        ack_t e;
        e.inst = inst; e.m = m; e.cyc = c; e.chk = chk; e.rd = rd; e.tag = tag;
        aq.push_back(e);
    endfunction

    function automatic void exp_lvl(input int inst, input lk_e k, input int c,
                                    input logic [15:0] v, input logic [63:0] tag);
        lvl_t e;
        e.inst = inst; e.k = k; e.cyc = c; e.v = v; e.tag = tag;
        lq.push_back(e);
    endfunction

    // Stimulus
    initial begin
        int d;
        int m;
        for (int i = 0; i < NI; i++) begin
            reset_b[i] = 1'b0;
            req0[i] = 1'b0; rnw0[i] = 1'b1; addr0[i] = '0; wdata0[i] = '0;
            req1[i] = 1'b0; rnw1[i] = 1'b1; addr1[i] = '0; wdata1[i] = '0;
        end

        // Reset for 3 edges, then 20 idle cycles.
        tick(3);
        for (int i = 0; i < NI; i++) begin
            exp_lvl(i, L_CEB,   cyc, 16'd1, "rst_ceb");
            exp_lvl(i, L_RNW,   cyc, 16'd1, "rst_rnw");
            exp_lvl(i, L_ADDR,  cyc, 16'd0, "rst_addr");
            exp_lvl(i, L_WDATA, cyc, 16'd0, "rst_wdat");
            exp_lvl(i, L_RD0,   cyc, 16'd0, "rst_rd0");
            exp_lvl(i, L_RD1,   cyc, 16'd0, "rst_rd1");
            reset_b[i] = 1'b1;
        end
        for (int j = 1; j <= 20; j++) begin
            exp_lvl(0, L_CEB, cyc + j, 16'd1, "idle_ceb");
            exp_lvl(0, L_RNW, cyc + j, 16'd1, "idle_rnw");
        end
        tick(20);

        // Single read, WAIT_STATES = 0.
        d = cyc;
        rnw0[0] = 1'b1; addr0[0] = 16'h0100; req0[0] = 1'b1;
        exp_lvl(0, L_CEB,  d,     16'd1,     "rd_ceb0");
        exp_lvl(0, L_CEB,  d + 1, 16'd0,     "rd_ceb1");
        exp_lvl(0, L_ADDR, d + 1, 16'h0100,  "rd_addr");
        exp_lvl(0, L_RNW,  d + 1, 16'd1,     "rd_rnw");
        exp_lvl(0, L_CEB,  d + 2, 16'd1,     "rd_ceb2");
        exp_ack(0, 0, d + 2, 1'b1, 16'hBEEF, "rd0");
        exp_lvl(0, L_RD0,  d + 3, 16'hBEEF,  "rd_hold");
        exp_lvl(0, L_RD1,  d + 3, 16'h0000,  "rd_oth");
        tick(3);
        req0[0] = 1'b0;
        tick(2);

        // Write then read back on m1, WAIT_STATES = 2, address 16'hFFFF.
        d = cyc;
        rnw1[1] = 1'b0; addr1[1] = 16'hFFFF; wdata1[1] = 16'h1234; req1[1] = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            exp_lvl(1, L_CEB, d + j, 16'd0, "wr_ceb");
            exp_lvl(1, L_RNW, d + j, 16'd0, "wr_rnw");
        end
        exp_lvl(1, L_ADDR,  d + 1, 16'hFFFF, "wr_addr");
        exp_lvl(1, L_WDATA, d + 2, 16'h1234, "wr_wdat");
        exp_lvl(1, L_CEB,   d + 4, 16'd1,    "wr_ceb4");
        exp_ack(1, 1, d + 4, 1'b0, 16'h0000, "wr1");
        tick(5);
        d = cyc;
        rnw1[1] = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            exp_lvl(1, L_CEB, d + j, 16'd0, "rb_ceb");
        end
        exp_lvl(1, L_RNW, d + 1, 16'd1, "rb_rnw");
        exp_ack(1, 1, d + 4, 1'b1, 16'h1234, "rb1");
        exp_lvl(1, L_RD0, d + 5, 16'h0000, "rb_oth");
        tick(5);
        req1[1] = 1'b0;
        tick(2);

        // Contention on instance 0 after a fresh reset: six accesses.
        reset_b[0] = 1'b0;
        tick(1);
        reset_b[0] = 1'b1;
        d = cyc;
        rnw0[0] = 1'b1; addr0[0] = 16'h0200; req0[0] = 1'b1;
        rnw1[0] = 1'b1; addr1[0] = 16'h0300; req1[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
`ifdef OPC_ARB_FIXED_PRIORITY_EN
            m = 0;
`else
            m = k % 2;
`endif
            exp_ack(0, m, d + 2 + 3 * k, 1'b1, (m == 1) ? 16'h2222 : 16'h1111, "cont");
        end
        tick(18);
        req0[0] = 1'b0; req1[0] = 1'b0;
        tick(2);

        // Reset during the 2nd ACCESS cycle, WAIT_STATES = 3.
        d = cyc;
        rnw0[2] = 1'b1; addr0[2] = 16'h0100; req0[2] = 1'b1;
        exp_lvl(2, L_CEB, d + 2, 16'd0, "ma_ceb");
        tick(2);
        reset_b[2] = 1'b0;
        req0[2] = 1'b0;
        exp_lvl(2, L_CEB, d + 3, 16'd1,    "ma_rst");
        exp_lvl(2, L_RD0, d + 3, 16'h0000, "ma_rd0");
        tick(1);
        reset_b[2] = 1'b1;
        d = cyc;
        rnw1[2] = 1'b1; addr1[2] = 16'h0300; req1[2] = 1'b1;
        exp_lvl(2, L_CEB,  d + 1, 16'd0,    "ma_ceb1");
        exp_lvl(2, L_ADDR, d + 1, 16'h0300, "ma_addr");
        exp_ack(2, 1, d + 5, 1'b1, 16'h2222, "ma1");
        tick(6);
        req1[2] = 1'b0;
        tick(2);

        // Back-to-back m0 on instance 1: new address presented on the ack edge.
        d = cyc;
        rnw0[1] = 1'b1; addr0[1] = 16'h0200; req0[1] = 1'b1;
        exp_ack(1, 0, d + 4, 1'b1, 16'h1111, "bb_a");
        tick(5);
        addr0[1] = 16'h0300;
        exp_lvl(1, L_CEB,  d + 5, 16'd1,    "bb_gap");
        exp_lvl(1, L_CEB,  d + 6, 16'd0,    "bb_ceb");
        exp_lvl(1, L_ADDR, d + 6, 16'h0300, "bb_addr");
        exp_ack(1, 0, d + 9, 1'b1, 16'h2222, "bb_b");
        tick(5);
        req0[1] = 1'b0;
        tick(5);

        done = 1'b1;
    end

    // Monitor: compares every ack and every scheduled port level.
    always @(negedge clk) begin
        int          idx;
        logic        av;
        logic [15:0] rv;
        logic [15:0] gv;
        ack_t        e;
        lvl_t        l;

        for (int i = 0; i < NI; i++) begin
            for (int mm = 0; mm < 2; mm++) begin
                av = (mm == 0) ? ack0[i] : ack1[i];
                rv = (mm == 0) ? rdata0[i] : rdata1[i];
                if (av === 1'b1) begin
                    idx = -1;
                    for (int k = 0; k < aq.size(); k++) begin
                        if (idx < 0 && aq[k].inst == i) idx = k;
                    end
                    total++;
                    if (idx < 0) begin
                        bad++;
                        $display("FAIL unexpected_ack inst=%0d got m=%0d cyc=%0d, none required",
                                 i, mm, cyc);
                    end else begin
                        e = aq[idx];
                        aq.delete(idx);
                        if (e.m != mm || e.cyc != cyc || (e.chk && rv !== e.rd)) begin
                            bad++;
                            $display("FAIL ack_%0s inst=%0d got m=%0d cyc=%0d rdata=%h, want m=%0d cyc=%0d rdata=%h",
                                     e.tag, i, mm, cyc, rv, e.m, e.cyc, e.rd);
                        end
                    end
                end
            end
        end

        for (int k = lq.size() - 1; k >= 0; k--) begin
            if (lq[k].cyc <= cyc) begin
                l = lq[k];
                lq.delete(k);
                case (l.k)
                    L_CEB:   gv = {15'd0, mem_ceb[l.inst]};
                    L_RNW:   gv = {15'd0, mem_rnw[l.inst]};
                    L_ADDR:  gv = mem_addr[l.inst];
                    L_WDATA: gv = mem_wdata[l.inst];
                    L_RD0:   gv = rdata0[l.inst];
                    default: gv = rdata1[l.inst];
                endcase
                total++;
                if (l.cyc != cyc || gv !== l.v) begin
                    bad++;
                    $display("FAIL %0s inst=%0d cyc=%0d got=%h want=%h (sched cyc=%0d)",
                             l.tag, l.inst, cyc, gv, l.v, l.cyc);
                end
            end
        end

        if (done || cyc > 3000) begin
            if (!done) begin
                total++;
                bad++;
                $display("FAIL timeout cyc=%0d got no end of stimulus, want end by 3000", cyc);
            end
            foreach (aq[k]) begin
                total++;
                bad++;
                $display("FAIL missing_ack_%0s inst=%0d got none, want m=%0d cyc=%0d",
                         aq[k].tag, aq[k].inst, aq[k].m, aq[k].cyc);
            end
            foreach (lq[k]) begin
                total++;
                bad++;
                $display("FAIL missing_%0s inst=%0d got unchecked, want=%h at cyc=%0d",
                         lq[k].tag, lq[k].inst, lq[k].v, lq[k].cyc);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

endmodule

// File: doc/opc5_mem_arbiter.md
Name: opc5_mem_arbiter

Overview:
Two-master arbiter that shares the single 64K x 16 system memory port between the OPC5 CPU (master 0) and a secondary requester such as a DMA or loader engine (master 1). Each master has a req/ack handshake. The block serialises their accesses onto one synchronous memory port with configurable wait states. It sits between the CPU/DMA buses and the memory model or RAM macro at system top level.

Parameters:
AW, 16, address width in bits
DW, 16, data width in bits
WAIT_STATES, 0, extra cycles the memory port is held per access (0..15)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_b  in  1  synchronous active-low reset
m0_req  in  1  master 0 (CPU) access request
m0_rnw  in  1  master 0 direction: 1 = read, 0 = write
m0_addr  in  AW  master 0 address
m0_wdata  in  DW  master 0 write data
m0_ack  out  1  master 0 completion pulse
m0_rdata  out  DW  master 0 read data, valid while m0_ack = 1
m1_req  in  1  master 1 access request
m1_rnw  in  1  master 1 direction: 1 = read, 0 = write
m1_addr  in  AW  master 1 address
m1_wdata  in  DW  master 1 write data
m1_ack  out  1  master 1 completion pulse
m1_rdata  out  DW  master 1 read data, valid while m1_ack = 1
mem_ceb  out  1  memory chip enable, active low
mem_rnw  out  1  memory direction: 1 = read, 0 = write
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid one cycle after address is presented

Behaviour:
- Reset (reset_b = 0 at a clock edge):
  - mem_ceb = 1, mem_rnw = 1, mem_addr = 0, mem_wdata = 0.
  - m0_ack = m1_ack = 0; m0_rdata = m1_rdata = 0.
  - State = IDLE; last_grant = 1, so master 0 wins the first tie.
- Reset asserted mid-access abandons the transaction. No ack is issued. A write in flight may or may not have committed.
- All outputs are registered.
- FSM states:
  - IDLE:
    - Sample the req inputs.
    - No request: stay in IDLE.
    - At least one request: pick the winner, latch its rnw/addr/wdata onto the mem_* outputs, drive mem_ceb = 0, load wait_cnt = WAIT_STATES, go to ACCESS.
  - ACCESS:
    - mem_* outputs are held stable.
    - wait_cnt != 0: decrement it and stay in ACCESS.
    - wait_cnt == 0: capture mem_rdata into the winner's rdata register (reads only), set mem_ceb = 1 and mem_rnw = 1, pulse the winner's ack, go to DONE.
  - DONE:
    - Ack is high for exactly this one cycle.
    - Update last_grant to the winner, clear ack, go to IDLE.
- Latency:
  - req sampled in IDLE at cycle 0.
  - Ack is high in cycle WAIT_STATES + 2.
  - Next arbitration is at cycle WAIT_STATES + 3.
  - One access per WAIT_STATES + 3 cycles.
- Handshake rules:
  - A master holds req, rnw, addr and wdata stable from assertion until it sees ack.
  - On the edge where ack is high, the master drops req or presents a new transaction.
  - req deasserted before ack is a protocol violation; the arbiter still completes the latched access and issues ack.
  - The non-winning master's ack and rdata stay unchanged.
- Arbitration:
  - Round robin.
  - If both masters request in IDLE, the master that was not last_grant wins.
  - A single requester always wins, whatever last_grant holds.
  - Under continuous contention grants alternate 0,1,0,1...
- Write: mem_rnw = 0 for all WAIT_STATES + 1 cycles in which mem_ceb = 0. The memory commits on the clock at which it samples.
- Boundaries:
  - addr 16'hFFFF passes through unchanged; the arbiter performs no address arithmetic.
  - WAIT_STATES = 0 gives ACCESS exactly one cycle.
  - wait_cnt is $clog2(WAIT_STATES + 1) bits, minimum 1.

Optional Feature:
OPC_ARB_FIXED_PRIORITY_EN
- Defined: master 0 always wins contention and last_grant is unused. Master 1 can starve under continuous CPU traffic.
- Undefined: round robin as described above.
- Latency and handshake are identical in both builds.

Decomposition:
- Package opc5_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - master index constants M_CPU = 0, M_AUX = 1;
  - default AW/DW localparams.
- One natural sub-module, opc5_arb_pick:
  - holds the last_grant register;
  - outputs the winner index and a valid flag from the two req inputs;
  - updates last_grant on a DONE strobe.
- The top level keeps the FSM, the wait counter and the output registers.

Test Plan:
- Reset then idle: hold reset_b = 0 for 3 cycles, release, no req → mem_ceb = 1, mem_rnw = 1, both acks 0 for 20 cycles.
- Single read, WAIT_STATES = 0: mem[16'h0100] = 16'hBEEF; m0 read 16'h0100 at cycle 0 → mem_ceb = 0 in cycle 1 only; m0_ack high in cycle 2 only; m0_rdata = 16'hBEEF.
- Write then read back, WAIT_STATES = 2: m1 writes 16'h1234 to 16'hFFFF, then reads it → mem_ceb low for 3 cycles per access; ack 4 cycles after each req sample; m1_rdata = 16'h1234; m0_ack never pulses.
- Contention: both masters hold req continuously for 6 accesses → grant order 0,1,0,1,0,1; the defined-macro build gives 0,0,0,0,0,0.
- Reset mid-access: WAIT_STATES = 3; reset_b low during the 2nd ACCESS cycle → next edge mem_ceb = 1 and no ack pulse; the next m1 request after release wins immediately with ack latency 5.
- Back-to-back single master: m0 presents a new address on its ack edge → next access starts WAIT_STATES + 3 cycles after the previous one; no cycle is lost or duplicated.
